// File: rtl/frogg_pkg.sv
// Shared constants for the frogger blocks: direction indices,
// hop FSM encoding and default timing at 25 MHz.
package frogg_pkg;

  localparam int DIR_UP = 0;
  localparam int DIR_DN = 1;
  localparam int DIR_LT = 2;
  localparam int DIR_RT = 3;

  localparam int unsigned C_DEBOUNCE_LIMIT = 32'd250000;
  localparam int unsigned C_REPEAT_DELAY   = 32'd12500000;
  localparam int unsigned C_REPEAT_PERIOD  = 32'd6250000;

  typedef enum logic [1:0] {
    HOP_IDLE   = 2'd0,
    HOP_ARMED  = 2'd1,
    HOP_REPEAT = 2'd2
  } hop_state_e;

  function automatic logic onehot4(
    input logic [3:0] v
  );
    return (v != 4'd0) &&
           ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/frogg_hop_input_if.sv
// One button lane: raw asynchronous level in,
// debounced level back out.
interface frogg_hop_input_if;

  logic raw;
  logic level;

  modport master (
    output raw,
    input  level
  );

  modport slave (
    input  raw,
    output level
  );

endinterface

// File: rtl/frogg_debounce.sv
// Two-flop synchroniser plus stable-count debouncer
// for one button.
module frogg_debounce #(
  parameter int unsigned LIMIT = 32'd250000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  frogg_hop_input_if.slave   btn
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q, level_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LIMIT - 32'd1) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn.raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn.level = level_q;

endmodule

// File: rtl/frogg_hop_input.sv
// Button debounce and hop-pulse generator for the frog.
// FROGG_AUTO_REPEAT_EN enables auto-repeat while held.
module frogg_hop_input
  import frogg_pkg::*;
#(
  parameter int unsigned c_DEBOUNCE_LIMIT = C_DEBOUNCE_LIMIT,
  parameter int unsigned c_REPEAT_DELAY   = C_REPEAT_DELAY,
  parameter int unsigned c_REPEAT_PERIOD  = C_REPEAT_PERIOD
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Btn_Up,
  input  logic       i_Btn_Dn,
  input  logic       i_Btn_Lt,
  input  logic       i_Btn_Rt,
  output logic [3:0] o_Btn_State,
  output logic       o_Hop_Up,
  output logic       o_Hop_Dn,
  output logic       o_Hop_Lt,
  output logic       o_Hop_Rt
);

  // Zero timing values are illegal; keep the block inert then.
  localparam bit ParamsOk = (c_DEBOUNCE_LIMIT != 0) &&
                            (c_REPEAT_DELAY   != 0) &&
                            (c_REPEAT_PERIOD  != 0);

  logic [3:0] raw;
  logic [3:0] level;

  assign raw[DIR_UP] = i_Btn_Up;
  assign raw[DIR_DN] = i_Btn_Dn;
  assign raw[DIR_LT] = i_Btn_Lt;
  assign raw[DIR_RT] = i_Btn_Rt;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    frogg_hop_input_if bif ();
    assign bif.raw  = raw[g];
    assign level[g] = bif.level;
    frogg_debounce #(
      .LIMIT (c_DEBOUNCE_LIMIT)
    ) u_db (
      .clk_i (i_Clk),
      .rst_i (i_Rst),
      .btn   (bif)
    );
  end

  hop_state_e state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [3:0] hop_q, hop_d;
  logic       dir_ok;

  assign dir_ok = ParamsOk && onehot4(level);

`ifdef FROGG_AUTO_REPEAT_EN
  logic [31:0] rpt_q, rpt_d;
  logic [31:0] rpt_lim;

  assign rpt_lim = (state_q == HOP_ARMED) ?
                   c_REPEAT_DELAY - 32'd1 :
                   c_REPEAT_PERIOD - 32'd1;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hop_d   = '0;
`ifdef FROGG_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    unique case (state_q)
      HOP_IDLE: begin
        if (dir_ok) begin
          hop_d   = level;
          dir_d   = level;
          state_d = HOP_ARMED;
`ifdef FROGG_AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end
      end
      HOP_ARMED, HOP_REPEAT: begin
        if (level != dir_q) begin
          state_d = HOP_IDLE;
        end
`ifdef FROGG_AUTO_REPEAT_EN
        else if (rpt_q == rpt_lim) begin
          hop_d   = dir_q;
          rpt_d   = '0;
          state_d = HOP_REPEAT;
        end else begin
          rpt_d = rpt_q + 32'd1;
        end
`endif
      end
      default: state_d = HOP_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= HOP_IDLE;
      dir_q   <= '0;
      hop_q   <= '0;
`ifdef FROGG_AUTO_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hop_q   <= hop_d;
`ifdef FROGG_AUTO_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign o_Btn_State = level;
  assign o_Hop_Up    = hop_q[DIR_UP];
  assign o_Hop_Dn    = hop_q[DIR_DN];
  assign o_Hop_Lt    = hop_q[DIR_LT];
  assign o_Hop_Rt    = hop_q[DIR_RT];

endmodule

// File: tb/tb_frogg_hop_input.sv
// Scoreboard bench for frogg_hop_input with short timing
// (debounce 4, delay 20, period 8).
module tb_frogg_hop_input;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic       lt  = 1'b0;
  logic       rt  = 1'b0;
  logic [3:0] state;
  logic       hu, hd, hl, hr;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] hop;
  } exp_t;

  exp_t q[$];

  frogg_hop_input #(
    .c_DEBOUNCE_LIMIT (4),
    .c_REPEAT_DELAY   (20),
    .c_REPEAT_PERIOD  (8)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Btn_Up    (up),
    .i_Btn_Dn    (dn),
    .i_Btn_Lt    (lt),
    .i_Btn_Rt    (rt),
    .o_Btn_State (state),
    .o_Hop_Up    (hu),
    .o_Hop_Dn    (hd),
    .o_Hop_Lt    (hl),
    .o_Hop_Rt    (hr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_hop(input int dt,
                            input logic [3:0] h);
    exp_t e;
    e.cyc = cyc + dt;
    e.hop = h;
    q.push_back(e);
  endtask

  task automatic chk_state(input string nm,
                           input logic [3:0] want);
    checks++;
    if (state !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d state=%b want %b",
               nm, cyc, state, want);
    end
  endtask

  task automatic chk_hops_zero(input string nm);
    checks++;
    if ({hr, hl, hd, hu} !== 4'b0000) begin
      errors++;
      $display("FAIL %s cyc=%0d hops=%b want 0000",
               nm, cyc, {hr, hl, hd, hu});
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] hv;
    exp_t       e;
    hv = {hr, hl, hd, hu};
    if (hv !== 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hop cyc=%0d hop=%b want none",
                 cyc, hv);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.hop !== hv) begin
          errors++;
          $display("FAIL hop cyc=%0d hop=%b want cyc=%0d hop=%b",
                   cyc, hv, e.cyc, e.hop);
        end
      end
    end
  end

  initial begin
    // Reset with every button held
    {rt, lt, dn, up} = 4'b1111;
    tick(2);
    chk_state("reset_state", 4'b0000);
    chk_hops_zero("reset_hops");

    // Release reset with Up alone held for 60 cycles
    {rt, lt, dn, up} = 4'b0001;
    rst = 1'b0;
    expect_hop(7, 4'b0001);
`ifdef FROGG_AUTO_REPEAT_EN
    expect_hop(27, 4'b0001);
    expect_hop(35, 4'b0001);
    expect_hop(43, 4'b0001);
    expect_hop(51, 4'b0001);
    expect_hop(59, 4'b0001);
`endif
    tick(5);
    chk_state("up_not_yet", 4'b0000);
    tick(1);
    chk_state("up_level", 4'b0001);
    tick(54);
    up = 1'b0;
    tick(10);
    chk_state("up_released", 4'b0000);

    // Short Lt glitch must be rejected
    lt = 1'b1;
    tick(3);
    lt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_state("lt_glitch", 4'b0000);
    end

    // Rt held, then Up added, then Rt released
    rt = 1'b1;
    expect_hop(7, 4'b1000);
    tick(8);
    up = 1'b1;
    tick(30);
    chk_state("rt_up_both", 4'b1001);
    rt = 1'b0;
    expect_hop(7, 4'b0001);
    tick(6);
    chk_state("up_after_rt", 4'b0001);
    tick(4);
    up = 1'b0;
    tick(10);
    chk_state("all_released", 4'b0000);

    // Reset in the middle of a Dn hold
    dn = 1'b1;
    expect_hop(7, 4'b0010);
`ifdef FROGG_AUTO_REPEAT_EN
    expect_hop(27, 4'b0010);
`endif
    tick(30);
    chk_state("dn_level", 4'b0010);
    rst = 1'b1;
    tick(1);
    chk_state("midrst_state", 4'b0000);
    chk_hops_zero("midrst_hops");
    tick(1);
    rst = 1'b0;
    expect_hop(7, 4'b0010);
    tick(6);
    chk_state("dn_relevel", 4'b0010);
    tick(4);
    dn = 1'b0;
    tick(10);

    // Long Rt hold, release, short re-press
    rt = 1'b1;
    expect_hop(7, 4'b1000);
`ifdef FROGG_AUTO_REPEAT_EN
    for (int k = 0; k < 10; k++) begin
      expect_hop(27 + 8 * k, 4'b1000);
    end
`endif
    tick(100);
    rt = 1'b0;
    tick(10);
    rt = 1'b1;
    expect_hop(7, 4'b1000);
    tick(20);
    rt = 1'b0;
    tick(10);
    chk_state("final_state", 4'b0000);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_hops left=%0d want 0 next_cyc=%0d",
               q.size(), q[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
